// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_mem_arbiter_pkg
// Brief   : Shared word, RAM-status and arbiter-state types for cache_mem_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package cache_mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    // RAM is word addressed on a byte bus: the byte offset is always zero.
    function automatic word_t word_align(input word_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cache_mem_arbiter
// Brief   : Shares one single-port RAM between an icache and a dcache; dcache
//           has priority, a saturating starvation counter bounds icache stall.
// Rev     : 1.0  initial release
// ============================================================================
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter word_t       ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output word_t     iload,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ram_err
);

    localparam int unsigned    SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          ram_err_q, ram_err_d;

    logic  dreq;
    logic  done;
    word_t rdata;

    assign dreq    = dREN | dWEN;
    assign done    = (ramstate == ACCESS) || (ramstate == ERROR);
    assign rdata   = (ramstate == ERROR) ? ERR_WORD : ramload;
    assign ram_err = ram_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            ram_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            ram_err_q <= ram_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        ram_err_d = ram_err_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;

        case (state_q)
            IDLE: begin
                if (dreq && !(iREN && (starve_q == STARVE_TOP))) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
                if (!iREN) begin
                    starve_d = '0;
                end
            end

            DGRANT: begin
                // A dropped request aborts silently: nothing driven, counter untouched.
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    ramaddr  = word_align(daddr);
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (done) begin
                        dwait   = 1'b0;
                        dload   = rdata;
                        state_d = IDLE;
                        if (iREN && (starve_q != STARVE_TOP)) begin
                            starve_d = starve_q + 1'b1;
                        end
                        if (ramstate == ERROR) begin
                            ram_err_d = 1'b1;
                        end
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = word_align(iaddr);
                    ramREN  = 1'b1;
                    if (done) begin
                        iwait    = 1'b0;
                        iload    = rdata;
                        state_d  = IDLE;
                        starve_d = '0;
                        if (ramstate == ERROR) begin
                            ram_err_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // While reset is held the in-flight grant is being discarded: show reset values.
        if (RST) begin
            iwait    = 1'b1;
            dwait    = 1'b1;
            iload    = '0;
            dload    = '0;
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
        end
    end

endmodule
`default_nettype wire
